// File: rtl/msft_tsmap_sram_ctrl.sv
// Arbiter for the single-port temporal-safety map SRAM: core read port, software
// register path and a hardware zeroing sweep share one SRAM port.
module msft_tsmap_sram_ctrl #(
  parameter int DEPTH = 2048,
  parameter int AW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tsmap_cs_i,
  input  logic [AW-1:0] tsmap_addr_i,
  output logic [31:0]   tsmap_rdata_o,
  input  logic          bus_req_i,
  input  logic          bus_we_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [3:0]    bus_be_i,
  input  logic [31:0]   bus_wdata_i,
  output logic          bus_gnt_o,
  output logic          bus_rvalid_o,
  output logic [31:0]   bus_rdata_o,
  output logic          bus_err_o,
  input  logic          clr_start_i,
  output logic          clr_busy_o,
  output logic          clr_done_o,
  output logic          sram_cs_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  output logic [31:0]   sram_wmask_o,
  input  logic [31:0]   sram_rdata_i
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  typedef struct packed {
    logic vld;
    logic err;
    logic rd;
  } bus_rsp_t;

  state_t      state_q, state_d;
  logic [AW:0] clr_ptr_q, clr_ptr_d;
  logic        core_hit, bus_in_rng, bus_hit, clr_wr;
  logic        core_rd_q;
  bus_rsp_t    rsp_q, rsp_d;
  logic [31:0] be_mask;

  for (genvar b = 0; b < 4; b++) begin : g_be
    assign be_mask[b*8 +: 8] = {8{bus_be_i[b]}};
  end

  assign core_hit   = tsmap_cs_i & ({1'b0, tsmap_addr_i} < DEPTH_W);
  assign clr_busy_o = (state_q == CLEAR);
  assign clr_done_o = (state_q == DONE);
  assign bus_gnt_o  = bus_req_i & ~tsmap_cs_i & ~clr_busy_o;
  assign bus_in_rng = ({1'b0, bus_addr_i} < DEPTH_W);
  assign bus_hit    = bus_gnt_o & bus_in_rng;
  // Any core strobe stalls the sweep, even an out-of-range one.
  assign clr_wr     = clr_busy_o & ~tsmap_cs_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      core_rd_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      core_rd_q <= core_hit;
      rsp_q     <= rsp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: if (clr_start_i) begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
      CLEAR: if (clr_wr) begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single SRAM port: core read, then sweep write, then bus access.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (core_hit) begin
      sram_cs_o   = 1'b1;
      sram_addr_o = tsmap_addr_i;
    end else if (clr_wr) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = clr_ptr_q[AW-1:0];
      sram_wmask_o = '1;
    end else if (bus_hit) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = bus_we_i;
      sram_addr_o  = bus_addr_i;
      sram_wdata_o = bus_wdata_i;
      sram_wmask_o = bus_we_i ? be_mask : '0;
    end
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.vld = bus_gnt_o;
    rsp_d.err = bus_gnt_o & ~bus_in_rng;
    rsp_d.rd  = bus_hit & ~bus_we_i;
  end

  assign bus_rvalid_o  = rsp_q.vld;
  assign bus_err_o     = rsp_q.err;
  assign bus_rdata_o   = rsp_q.rd  ? sram_rdata_i : '0;
  assign tsmap_rdata_o = core_rd_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_msft_tsmap_sram_ctrl.sv
// Directed bench for msft_tsmap_sram_ctrl with a behavioural 1-cycle SRAM model.
module tb_msft_tsmap_sram_ctrl;
  localparam int DEPTH = 2048;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          tsmap_cs;
  logic [AW-1:0] tsmap_addr;
  logic [31:0]   tsmap_rdata;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_gnt, bus_rvalid, bus_err;
  logic [31:0]   bus_rdata;
  logic          clr_start, clr_busy, clr_done;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_wmask;
  logic [31:0]   sram_rdata = '0;

  logic [31:0]   mem [DEPTH];
  int            n_chk = 0;
  int            n_fail = 0;

  msft_tsmap_sram_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .tsmap_cs_i(tsmap_cs), .tsmap_addr_i(tsmap_addr), .tsmap_rdata_o(tsmap_rdata),
    .bus_req_i(bus_req), .bus_we_i(bus_we), .bus_addr_i(bus_addr), .bus_be_i(bus_be),
    .bus_wdata_i(bus_wdata), .bus_gnt_o(bus_gnt), .bus_rvalid_o(bus_rvalid),
    .bus_rdata_o(bus_rdata), .bus_err_o(bus_err),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs && sram_we && sram_addr < DEPTH)
      mem[sram_addr] = (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
    if (sram_cs && !sram_we && sram_addr < DEPTH)
      sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  task automatic fill_pat();
    for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
  endtask

  // Runs a sweep with n_reads core reads interleaved (every 5th cycle) while a bus
  // read of word 5 is held pending; checks timing, sweep addresses and read data.
  task automatic run_clear(input int n_reads, input int exp_cyc, input string tag);
    int cyc, k, nrd, gnt_hi, bad_wr;
    logic pend, rd;
    logic [31:0] pexp;
    cyc = 0; k = 0; nrd = 0; gnt_hi = 0; bad_wr = 0; pend = 1'b0; pexp = '0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 16'd5;
    check({tag, "_busy_start"}, clr_busy, 1);
    while (clr_busy && cyc < 5000) begin
      if (pend) check({tag, "_core_rd"}, tsmap_rdata, pexp);
      pend = 1'b0;
      rd = (cyc % 5 == 2) && (nrd < n_reads);
      tsmap_cs = rd;
      if (rd) begin
        if ((nrd % 2 == 1) && k > 0) begin
          tsmap_addr = 16'(k - 1); pexp = '0;
        end else begin
          tsmap_addr = 16'(k); pexp = pat(k);
        end
        pend = 1'b1;
        nrd++;
      end
      #1;
      if (bus_gnt) gnt_hi++;
      if (!rd) begin
        if (sram_cs !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 16'(k) || sram_wmask !== '1)
          bad_wr++;
        k++;
      end
      cyc++;
      tick();
    end
    tsmap_cs = 1'b0;
    if (pend) check({tag, "_core_rd_last"}, tsmap_rdata, pexp);
    #1;
    check({tag, "_busy_cycles"}, cyc, exp_cyc);
    check({tag, "_sweep_wr"}, bad_wr, 0);
    check({tag, "_gnt_during_busy"}, gnt_hi, 0);
    check({tag, "_done"}, clr_done, 1);
    check({tag, "_busy_at_done"}, clr_busy, 0);
    check({tag, "_gnt_at_done"}, bus_gnt, 1);
    tick();
    bus_req = 1'b0;
    check({tag, "_done_pulse_end"}, clr_done, 0);
    check({tag, "_rvalid_after"}, bus_rvalid, 1);
    check({tag, "_rdata_after"}, bus_rdata, 0);
  endtask

  initial begin
    int errs;
    rst = 1'b1;
    tsmap_cs = 0; tsmap_addr = '0; bus_req = 0; bus_we = 0; bus_addr = '0;
    bus_be = '0; bus_wdata = '0; clr_start = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
    repeat (3) tick();
    check("rst_gnt", bus_gnt, 0);
    check("rst_rvalid", bus_rvalid, 0);
    check("rst_err", bus_err, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    check("rst_sram_cs", sram_cs, 0);
    check("rst_tsmap_rdata", tsmap_rdata, 0);
    rst = 1'b0;
    tick();

    // byte-masked write then core read of the same word
    bus_req = 1; bus_we = 1; bus_addr = 16'd5; bus_be = 4'b0011; bus_wdata = 32'hA5A5_0F0F;
    #1;
    check("t1_gnt", bus_gnt, 1);
    check("t1_wmask", sram_wmask, 32'h0000_FFFF);
    tick();
    bus_req = 0; tsmap_cs = 1; tsmap_addr = 16'd5;
    check("t1_rvalid", bus_rvalid, 1);
    check("t1_wr_rdata", bus_rdata, 0);
    tick();
    tsmap_cs = 0;
    check("t1_core_rdata", tsmap_rdata, 32'hFFFF_0F0F);

    // read-after-write on consecutive grants
    bus_req = 1; bus_we = 1; bus_addr = 16'd6; bus_be = 4'hF; bus_wdata = 32'h1234_5678;
    tick();
    bus_we = 0;
    #1;
    check("raw_gnt2", bus_gnt, 1);
    tick();
    bus_req = 0;
    check("raw_rvalid", bus_rvalid, 1);
    check("raw_rdata", bus_rdata, 32'h1234_5678);

    // core strobe blocks the bus for 3 cycles
    bus_req = 1; bus_we = 0; bus_addr = 16'd5; tsmap_cs = 1; tsmap_addr = 16'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t2_gnt_blocked", bus_gnt, 0);
      tick();
      check("t2_core_rdata", tsmap_rdata, 32'hFFFF_FFFF);
      check("t2_no_rvalid", bus_rvalid, 0);
    end
    tsmap_cs = 0;
    #1;
    check("t2_gnt", bus_gnt, 1);
    tick();
    bus_req = 0;
    check("t2_rvalid", bus_rvalid, 1);
    check("t2_rdata", bus_rdata, 32'hFFFF_0F0F);

    // out-of-range accesses
    bus_req = 1; bus_we = 0; bus_addr = 16'd2048;
    #1;
    check("t5_gnt", bus_gnt, 1);
    check("t5_sram_cs", sram_cs, 0);
    tick();
    bus_req = 0;
    check("t5_rvalid", bus_rvalid, 1);
    check("t5_err", bus_err, 1);
    check("t5_rdata", bus_rdata, 0);
    tsmap_cs = 1; tsmap_addr = 16'hFFFF;
    #1;
    check("t5_core_sram_cs", sram_cs, 0);
    tick();
    tsmap_cs = 0;
    check("t5_core_rdata", tsmap_rdata, 0);
    check("t5_err_clears", bus_err, 0);

    // full sweep, no core traffic
    run_clear(0, 2048, "t3");
    errs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) errs++;
    check("t3_nonzero_words", errs, 0);

    // sweep with 100 interleaved core reads
    fill_pat();
    run_clear(100, 2148, "t4");

    // reset aborts a sweep at clr_ptr = 700
    fill_pat();
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (700) tick();
    rst = 1;
    #1;
    check("t6_busy_rst", clr_busy, 0);
    check("t6_done_rst", clr_done, 0);
    tick();
    rst = 0;
    tick();
    check("t6_no_done", clr_done, 0);
    errs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ((i < 700) ? 32'h0 : pat(i))) errs++;
    check("t6_partial_map", errs, 0);
    check("t6_word699", mem[699], 0);
    check("t6_word700", mem[700], pat(700));
    run_clear(0, 2048, "t6r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
